// File: rtl/adxl345_sample_averager_pkg.sv
// Shared defaults and state encoding for the ADXL345 block-averaging stage.
package adxl345_sample_averager_pkg;

  localparam int OFFSET_DEF       = 15;
  localparam int LOG2_SAMPLES_DEF = 3;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } avg_state_e;

endpackage

// File: rtl/adxl345_sample_averager_if.sv
// Sample/strobe bundle between i2c_controller, the averager and the data converter.
interface adxl345_sample_averager_if
  import adxl345_sample_averager_pkg::*;
#(
  parameter int offset_p       = OFFSET_DEF,
  parameter int log2_samples_p = LOG2_SAMPLES_DEF
);

  logic                      Bypass_i;
  logic                      Data_Available_i;
  logic signed [offset_p:0]  X_i;
  logic signed [offset_p:0]  Y_i;
  logic signed [offset_p:0]  Z_i;
  logic signed [offset_p:0]  X_o;
  logic signed [offset_p:0]  Y_o;
  logic signed [offset_p:0]  Z_o;
  logic                      Data_Available_o;
  logic [log2_samples_p-1:0] Count_o;

  modport master (
    output Bypass_i, Data_Available_i, X_i, Y_i, Z_i,
    input  X_o, Y_o, Z_o, Data_Available_o, Count_o
  );

  modport slave (
    input  Bypass_i, Data_Available_i, X_i, Y_i, Z_i,
    output X_o, Y_o, Z_o, Data_Available_o, Count_o
  );

endinterface

// File: rtl/adxl345_sample_averager_axis.sv
// One axis: sign-extended accumulator plus floor-averaged (or bypassed) output register.
module adxl345_axis_accumulator
  import adxl345_sample_averager_pkg::*;
#(
  parameter int offset_p       = OFFSET_DEF,
  parameter int log2_samples_p = LOG2_SAMPLES_DEF
) (
  input  logic                     Clk_i,
  input  logic                     Reset_i,
  input  logic                     take,
  input  logic                     last,
  input  logic                     clr,
  input  logic                     bypass,
  input  logic signed [offset_p:0] sample,
  output logic signed [offset_p:0] avg
);

  localparam int ACC_W = offset_p + 1 + log2_samples_p;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;

  assign sample_ext = {{log2_samples_p{sample[offset_p]}}, sample};
  assign sum        = acc + sample_ext;

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      acc <= '0;
      avg <= '0;
    end else begin
      // A sample arriving on the same cycle as a mode change opens the new block.
      if (clr || bypass) begin
        acc <= (take && !bypass) ? sample_ext : '0;
      end else if (take) begin
        acc <= last ? '0 : sum;
      end

      // Dropping the low bits of the full sum is the arithmetic shift (floor).
      if (take && bypass) begin
        avg <= sample;
      end else if (take && last) begin
        avg <= sum[offset_p+log2_samples_p:log2_samples_p];
      end
    end
  end

endmodule

// File: rtl/adxl345_sample_averager.sv
// Block averager: rising-edge sample capture, per-axis accumulation of 2^log2_samples_p samples, one-cycle output strobe.
module adxl345_sample_averager
  import adxl345_sample_averager_pkg::*;
#(
  parameter int offset_p       = OFFSET_DEF,
  parameter int log2_samples_p = LOG2_SAMPLES_DEF
) (
  input  logic                      Clk_i,
  input  logic                      Reset_i,
  adxl345_sample_averager_if.slave  bus
);

  localparam logic [log2_samples_p-1:0] CNT_LAST = '1;
  localparam logic [log2_samples_p-1:0] CNT_ONE  = log2_samples_p'(1);

  avg_state_e                state;
  avg_state_e                state_nxt;
  logic                      avail_q;
  logic                      bypass_q;
  logic                      take;
  logic                      bypass_chg;
  logic                      last;
  logic                      strobe;
  logic [log2_samples_p-1:0] count;
  logic signed [offset_p:0]  x_avg;
  logic signed [offset_p:0]  y_avg;
  logic signed [offset_p:0]  z_avg;

  assign take       = bus.Data_Available_i & ~avail_q;
  assign bypass_chg = bus.Bypass_i ^ bypass_q;
  assign last       = (count == CNT_LAST) & ~bus.Bypass_i & ~bypass_chg;

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state    <= ACCUM;
      avail_q  <= 1'b0;
      bypass_q <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      avail_q  <= bus.Data_Available_i;
      bypass_q <= bus.Bypass_i;
      if (bypass_chg) begin
        count <= (take && !bus.Bypass_i) ? CNT_ONE : '0;
      end else if (bus.Bypass_i) begin
        count <= '0;
      end else if (take) begin
        count <= last ? '0 : count + CNT_ONE;
      end
    end
  end

  // A take during EMIT is absorbed by the accumulators; only the strobe is state-driven.
  always_comb begin
    state_nxt = state;
    strobe    = 1'b0;
    case (state)
      ACCUM: begin
        if (take && (bus.Bypass_i || last)) state_nxt = EMIT;
      end
      EMIT: begin
        strobe    = 1'b1;
        state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  adxl345_axis_accumulator #(.offset_p(offset_p), .log2_samples_p(log2_samples_p)) u_axis_x (
    .Clk_i  (Clk_i),
    .Reset_i(Reset_i),
    .take   (take),
    .last   (last),
    .clr    (bypass_chg),
    .bypass (bus.Bypass_i),
    .sample (bus.X_i),
    .avg    (x_avg)
  );

  adxl345_axis_accumulator #(.offset_p(offset_p), .log2_samples_p(log2_samples_p)) u_axis_y (
    .Clk_i  (Clk_i),
    .Reset_i(Reset_i),
    .take   (take),
    .last   (last),
    .clr    (bypass_chg),
    .bypass (bus.Bypass_i),
    .sample (bus.Y_i),
    .avg    (y_avg)
  );

  adxl345_axis_accumulator #(.offset_p(offset_p), .log2_samples_p(log2_samples_p)) u_axis_z (
    .Clk_i  (Clk_i),
    .Reset_i(Reset_i),
    .take   (take),
    .last   (last),
    .clr    (bypass_chg),
    .bypass (bus.Bypass_i),
    .sample (bus.Z_i),
    .avg    (z_avg)
  );

  assign bus.X_o              = x_avg;
  assign bus.Y_o              = y_avg;
  assign bus.Z_o              = z_avg;
  assign bus.Data_Available_o = strobe;
  assign bus.Count_o          = count;

endmodule

// File: tb/tb_adxl345_sample_averager.sv
// Randomized + directed bench for adxl345_sample_averager against a cycle-level arithmetic model.
module tb_adxl345_sample_averager;

  localparam int OFF = 15;
  localparam int L   = 3;
  localparam int N   = 1 << L;
  localparam int W   = OFF + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adxl345_sample_averager_if #(.offset_p(OFF), .log2_samples_p(L)) bus ();

  adxl345_sample_averager #(.offset_p(OFF), .log2_samples_p(L)) dut (
    .Clk_i  (clk),
    .Reset_i(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-axis integer sums, sample counter, held outputs.
  int m_sum[3];
  int m_out[3];
  int m_in[3];
  int m_cnt;
  bit m_strobe;
  bit m_avail_q;
  bit m_bypass_q;
  bit m_take;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_sum[i] = 0;
        m_out[i] = 0;
      end
      m_cnt      = 0;
      m_strobe   = 0;
      m_avail_q  = 0;
      m_bypass_q = 0;
    end else begin
      m_in[0] = int'(bus.X_i);
      m_in[1] = int'(bus.Y_i);
      m_in[2] = int'(bus.Z_i);
      m_take   = bus.Data_Available_i && !m_avail_q;
      m_strobe = 0;
      if (bus.Bypass_i != m_bypass_q) begin
        for (int i = 0; i < 3; i++) m_sum[i] = 0;
        m_cnt = 0;
      end
      if (m_take) begin
        if (bus.Bypass_i) begin
          for (int i = 0; i < 3; i++) m_out[i] = m_in[i];
          m_strobe = 1;
        end else begin
          for (int i = 0; i < 3; i++) m_sum[i] += m_in[i];
          m_cnt++;
          if (m_cnt == N) begin
            for (int i = 0; i < 3; i++) begin
              m_out[i] = m_sum[i] >>> L;
              m_sum[i] = 0;
            end
            m_cnt    = 0;
            m_strobe = 1;
          end
        end
      end
      m_avail_q  = bus.Data_Available_i;
      m_bypass_q = bus.Bypass_i;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("strobe", int'(bus.Data_Available_o), int'(m_strobe));
      check("count",  int'(bus.Count_o), m_cnt);
      check("x_out",  int'(bus.X_o), m_out[0]);
      check("y_out",  int'(bus.Y_o), m_out[1]);
      check("z_out",  int'(bus.Z_o), m_out[2]);
    end
  end

  int n_strobes = 0;
  int sx, sy, sz;
  always @(negedge clk) begin
    if (rst_n && bus.Data_Available_o) begin
      n_strobes++;
      sx = int'(bus.X_o);
      sy = int'(bus.Y_o);
      sz = int'(bus.Z_o);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input int z, input int hold);
    bus.X_i = W'(x);
    bus.Y_i = W'(y);
    bus.Z_i = W'(z);
    bus.Data_Available_i = 1'b1;
    for (int i = 0; i < hold; i++) @(negedge clk);
    #1;
    bus.Data_Available_i = 1'b0;
    @(negedge clk);
    #1;
  endtask

  int base;
  int v[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Bypass_i         = 1'b0;
    bus.Data_Available_i = 1'b0;
    bus.X_i = '0;
    bus.Y_i = '0;
    bus.Z_i = '0;
    idle(3);
    check("reset_x", int'(bus.X_o), 0);
    check("reset_strobe", int'(bus.Data_Available_o), 0);
    check("reset_count", int'(bus.Count_o), 0);
    rst_n = 1'b1;
    idle(2);

    // Plain averaging with Count_o stepping.
    base = n_strobes;
    for (int i = 1; i <= N; i++) begin
      send(100, -200, 256, 1);
      check("avg_count_step", int'(bus.Count_o), i % N);
    end
    check("avg_nstrobe", n_strobes - base, 1);
    check("avg_x", sx, 100);
    check("avg_y", sy, -200);
    check("avg_z", sz, 256);

    // Floor rounding.
    for (int i = 0; i < N; i++) send((i % 2 == 0) ? -3 : -4, 0, 0, 1);
    check("floor_neg", sx, -4);
    for (int i = 0; i < N; i++) send((i == 0) ? 1 : 0, 0, 0, 1);
    check("floor_pos", sx, 0);

    // Extremes.
    for (int i = 0; i < N; i++) send(32767, -32768, 0, 1);
    check("ext_max", sx, 32767);
    check("ext_min", sy, -32768);

    // Held-high level input: one take per hold.
    base = n_strobes;
    for (int i = 0; i < N; i++) send(7, 7, 7, 5);
    check("level_nstrobe", n_strobes - base, 1);
    check("level_x", sx, 7);

    // Reset mid-block.
    for (int i = 0; i < 5; i++) send(1000, 1000, 1000, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_x", int'(bus.X_o), 0);
    check("rst_mid_count", int'(bus.Count_o), 0);
    check("rst_mid_strobe", int'(bus.Data_Available_o), 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    base = n_strobes;
    for (int i = 0; i < N; i++) send(10, 10, 10, 1);
    check("rst_after_nstrobe", n_strobes - base, 1);
    check("rst_after_x", sx, 10);

    // Bypass pass-through.
    bus.Bypass_i = 1'b1;
    idle(1);
    base = n_strobes;
    send(5, 6, 7, 1);
    check("byp_x1", sx, 5);
    send(-9, 0, 0, 1);
    check("byp_x2", sx, -9);
    check("byp_nstrobe", n_strobes - base, 2);
    bus.Bypass_i = 1'b0;
    idle(1);

    // Partial block discarded by a bypass toggle.
    for (int i = 0; i < 3; i++) send(50, 50, 50, 1);
    check("partial_count", int'(bus.Count_o), 3);
    bus.Bypass_i = 1'b1;
    idle(1);
    bus.Bypass_i = 1'b0;
    idle(1);
    check("toggle_count", int'(bus.Count_o), 0);
    check("toggle_keep_x", int'(bus.X_o), -9);
    base = n_strobes;
    for (int i = 0; i < N - 1; i++) send(20, 20, 20, 1);
    check("fresh_nostrobe", n_strobes - base, 0);
    send(20, 20, 20, 1);
    check("fresh_nstrobe", n_strobes - base, 1);
    check("fresh_x", sx, 20);

    // Randomized traffic with occasional bypass toggles.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.Bypass_i = ~bus.Bypass_i;
        idle(1);
      end
      for (int a = 0; a < 3; a++) begin
        case ($urandom_range(0, 7))
          0:       v[a] = 32767;
          1:       v[a] = -32768;
          default: v[a] = int'($urandom_range(0, 65535)) - 32768;
        endcase
      end
      send(v[0], v[1], v[2], int'($urandom_range(1, 3)));
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
